// File: rtl/simon_seq_engine.sv
`default_nettype none
// ============================================================================
// Module   : simon_seq_engine
// Purpose  : Parametrised Simon game sequencer. A free-running 16-bit Galois
//            LFSR supplies one new colour per round, which is appended to a
//            sequence RAM. Each round the whole sequence is played back with
//            timed lit/dark phases, then the player's presses are checked
//            against it with an inactivity timeout.
// Ports    : Clk          - system clock
//            Reset        - asynchronous, active-high reset
//            Start        - level, starts/restarts a game
//            ON           - game-enable switch; low forces EXIT
//            Btn          - debounced single-cycle press pulses, bit k = colour k
//            state_onehot - {EXIT,WIN,LOST,INPUT,GAP,SHOW,GEN,INITIAL}
//            level        - current round (1..MAX_LEVEL), 0 when idle
//            score        - accumulated, saturating score
//            show_valid   - high while a playback colour is lit
//            show_color   - colour being played, 0 when dark
//            press_ok     - one-cycle pulse after each correct press
//            lost_timeout - high in LOST when the loss was a timeout
// Revision : 1.0 - initial release
// ============================================================================
module simon_seq_engine #(
    parameter int          MAX_LEVEL      = 16,
    parameter int          COLOR_W        = 2,
    parameter int          SHOW_CYCLES    = 25000000,
    parameter int          GAP_CYCLES     = 12500000,
    parameter int          TIMEOUT_CYCLES = 250000000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          SCORE_W        = 8,
    localparam int         NUM_COLORS     = 2**COLOR_W,
    localparam int         LEVEL_W        = $clog2(MAX_LEVEL+1)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  ON,
    input  logic [NUM_COLORS-1:0] Btn,
    output logic [7:0]            state_onehot,
    output logic [LEVEL_W-1:0]    level,
    output logic [SCORE_W-1:0]    score,
    output logic                  show_valid,
    output logic [COLOR_W-1:0]    show_color,
    output logic                  press_ok,
    output logic                  lost_timeout
);

    localparam int c_t_max1   = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int c_t_max    = (c_t_max1 > TIMEOUT_CYCLES) ? c_t_max1 : TIMEOUT_CYCLES;
    localparam int c_timer_w  = $clog2(c_t_max + 1);
    localparam int c_idx_w    = $clog2(MAX_LEVEL);
    // Galois feedback mask for x^16 + x^14 + x^13 + x^11
    localparam logic [15:0] c_lfsr_mask = 16'hB400;

    typedef enum logic [7:0] {
        S_INITIAL = 8'b0000_0001,
        S_GEN     = 8'b0000_0010,
        S_SHOW    = 8'b0000_0100,
        S_GAP     = 8'b0000_1000,
        S_INPUT   = 8'b0001_0000,
        S_LOST    = 8'b0010_0000,
        S_WIN     = 8'b0100_0000,
        S_EXIT    = 8'b1000_0000
    } state_t;

    state_t                 r_state,   w_state_nx;
    logic [LEVEL_W-1:0]     r_level,   w_level_nx;
    logic [SCORE_W-1:0]     r_score,   w_score_nx;
    logic [c_idx_w-1:0]     r_idx,     w_idx_nx;
    logic [c_timer_w-1:0]   r_timer,   w_timer_nx;
    logic                   r_press_ok, w_press_ok_nx;
    logic                   r_lost_to,  w_lost_to_nx;
    logic [15:0]            r_lfsr;
    logic                   w_seq_we;

    logic [COLOR_W-1:0]     r_seq [MAX_LEVEL];

    logic [COLOR_W-1:0]     w_cur_color;
    logic [NUM_COLORS-1:0]  w_expect_btn;
    logic                   w_last_idx;
    logic [c_idx_w-1:0]     w_gen_idx;
    logic [SCORE_W:0]       w_score_sum;

    assign w_cur_color  = r_seq[r_idx];
    assign w_expect_btn = NUM_COLORS'(1) << w_cur_color;
    assign w_last_idx   = (LEVEL_W'(r_idx) == (r_level - LEVEL_W'(1)));
    assign w_gen_idx    = c_idx_w'(r_level - LEVEL_W'(1));
    assign w_score_sum  = {1'b0, r_score} + (SCORE_W+1)'(r_level);

    // LFSR runs continuously so the colour drawn at GEN depends on how long
    // the player took, which is what makes the sequence unpredictable.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_mask : 16'h0000);
        end
    end

    // Sequence RAM: no reset, every entry is written in GEN before it is read.
    always_ff @(posedge Clk) begin
        if (w_seq_we) begin
            r_seq[w_gen_idx] <= r_lfsr[COLOR_W-1:0];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_INITIAL;
            r_level    <= '0;
            r_score    <= '0;
            r_idx      <= '0;
            r_timer    <= '0;
            r_press_ok <= 1'b0;
            r_lost_to  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_level    <= w_level_nx;
            r_score    <= w_score_nx;
            r_idx      <= w_idx_nx;
            r_timer    <= w_timer_nx;
            r_press_ok <= w_press_ok_nx;
            r_lost_to  <= w_lost_to_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_level_nx    = r_level;
        w_score_nx    = r_score;
        w_idx_nx      = r_idx;
        w_timer_nx    = r_timer;
        w_press_ok_nx = 1'b0;
        w_lost_to_nx  = r_lost_to;
        w_seq_we      = 1'b0;

        case (r_state)
            S_EXIT, S_INITIAL: begin
                w_level_nx   = '0;
                w_score_nx   = '0;
                w_lost_to_nx = 1'b0;
                if (Start && ON) begin
                    if (r_state == S_EXIT) begin
                        w_state_nx = S_INITIAL;
                    end else begin
                        w_state_nx = S_GEN;
                        w_level_nx = LEVEL_W'(1);
                    end
                end
            end
            S_GEN: begin
                w_seq_we   = 1'b1;
                w_idx_nx   = '0;
                w_timer_nx = '0;
                w_state_nx = S_SHOW;
            end
            S_SHOW: begin
                if (r_timer == c_timer_w'(SHOW_CYCLES - 1)) begin
                    w_timer_nx = '0;
                    w_state_nx = S_GAP;
                end else begin
                    w_timer_nx = r_timer + c_timer_w'(1);
                end
            end
            S_GAP: begin
                if (r_timer == c_timer_w'(GAP_CYCLES - 1)) begin
                    w_timer_nx = '0;
                    if (w_last_idx) begin
                        w_idx_nx   = '0;
                        w_state_nx = S_INPUT;
                    end else begin
                        w_idx_nx   = r_idx + c_idx_w'(1);
                        w_state_nx = S_SHOW;
                    end
                end else begin
                    w_timer_nx = r_timer + c_timer_w'(1);
                end
            end
            S_INPUT: begin
                // A press always takes priority over a coincident timeout.
                if (Btn != '0) begin
                    if (Btn == w_expect_btn) begin
                        w_press_ok_nx = 1'b1;
                        w_timer_nx    = '0;
                        if (!w_last_idx) begin
                            w_idx_nx = r_idx + c_idx_w'(1);
                        end else begin
                            w_score_nx = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
                            if (r_level == LEVEL_W'(MAX_LEVEL)) begin
                                w_state_nx = S_WIN;
                            end else begin
                                w_level_nx = r_level + LEVEL_W'(1);
                                w_state_nx = S_GEN;
                            end
                        end
                    end else begin
                        w_lost_to_nx = 1'b0;
                        w_state_nx   = S_LOST;
                    end
                end else if (r_timer == c_timer_w'(TIMEOUT_CYCLES - 1)) begin
                    w_lost_to_nx = 1'b1;
                    w_state_nx   = S_LOST;
                end else begin
                    w_timer_nx = r_timer + c_timer_w'(1);
                end
            end
            S_LOST, S_WIN: begin
                if (Start && ON) begin
                    w_state_nx   = S_INITIAL;
                    w_level_nx   = '0;
                    w_score_nx   = '0;
                    w_lost_to_nx = 1'b0;
                end
            end
            default: begin
                w_state_nx   = S_INITIAL;
                w_level_nx   = '0;
                w_score_nx   = '0;
                w_idx_nx     = '0;
                w_timer_nx   = '0;
                w_lost_to_nx = 1'b0;
            end
        endcase

        // Switching the game off wins over every other transition.
        if (!ON && (r_state != S_EXIT)) begin
            w_state_nx    = S_EXIT;
            w_level_nx    = '0;
            w_score_nx    = '0;
            w_idx_nx      = '0;
            w_timer_nx    = '0;
            w_press_ok_nx = 1'b0;
            w_lost_to_nx  = 1'b0;
            w_seq_we      = 1'b0;
        end
    end

    assign state_onehot = r_state;
    assign level        = r_level;
    assign score        = r_score;
    assign show_valid   = (r_state == S_SHOW);
    assign show_color   = show_valid ? w_cur_color : '0;
    assign press_ok     = r_press_ok;
    assign lost_timeout = r_lost_to;

endmodule
`default_nettype wire

// File: tb/tb_simon_seq_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_seq_engine
// Purpose  : Self-checking bench for simon_seq_engine with a small game:
//            three rounds, 4-cycle lit phase, 2-cycle gap, 20-cycle timeout.
//            A behavioural game model runs alongside the DUT and every output
//            is compared against it on each falling clock edge; directed
//            scenarios add hand-computed expectations on top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simon_seq_engine;

    localparam int ML = 3;
    localparam int SC = 4;
    localparam int GC = 2;
    localparam int TO = 20;

    // Model phase numbers follow the bit positions of state_onehot.
    localparam int P_INIT  = 0;
    localparam int P_GEN   = 1;
    localparam int P_SHOW  = 2;
    localparam int P_GAP   = 3;
    localparam int P_INPUT = 4;
    localparam int P_LOST  = 5;
    localparam int P_WIN   = 6;
    localparam int P_EXIT  = 7;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       ON = 1'b0;
    logic [3:0] Btn = 4'b0;
    logic [7:0] state_onehot;
    logic [1:0] level;
    logic [7:0] score;
    logic       show_valid;
    logic [1:0] show_color;
    logic       press_ok;
    logic       lost_timeout;

    int checks = 0;
    int failures = 0;

    simon_seq_engine #(
        .MAX_LEVEL(ML), .COLOR_W(2), .SHOW_CYCLES(SC), .GAP_CYCLES(GC),
        .TIMEOUT_CYCLES(TO), .LFSR_SEED(16'hACE1), .SCORE_W(8)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ON(ON), .Btn(Btn),
        .state_onehot(state_onehot), .level(level), .score(score),
        .show_valid(show_valid), .show_color(show_color),
        .press_ok(press_ok), .lost_timeout(lost_timeout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural game model ----------------
    int          m_ph = P_INIT, m_level = 0, m_score = 0, m_pos = 0, m_elapsed = 0;
    bit          m_press = 0, m_lto = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    int          m_seq [ML];

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_ph = P_INIT; m_level = 0; m_score = 0; m_pos = 0; m_elapsed = 0;
            m_press = 0; m_lto = 0; m_lfsr = 16'hACE1;
        end else begin
            logic [15:0] cur;
            cur = m_lfsr;
            m_lfsr = (cur >> 1) ^ (cur[0] ? 16'hB400 : 16'h0000);
            m_press = 0;
            if (!ON && m_ph != P_EXIT) begin
                m_ph = P_EXIT; m_level = 0; m_score = 0; m_lto = 0;
            end else begin
                case (m_ph)
                    P_EXIT:  if (Start && ON) m_ph = P_INIT;
                    P_INIT:  if (Start && ON) begin m_ph = P_GEN; m_level = 1; m_score = 0; end
                    P_GEN: begin
                        m_seq[m_level-1] = int'(cur % 4);
                        m_pos = 0; m_elapsed = 0; m_ph = P_SHOW;
                    end
                    P_SHOW: begin
                        m_elapsed++;
                        if (m_elapsed == SC) begin m_elapsed = 0; m_ph = P_GAP; end
                    end
                    P_GAP: begin
                        m_elapsed++;
                        if (m_elapsed == GC) begin
                            m_elapsed = 0;
                            if (m_pos == m_level - 1) begin m_pos = 0; m_ph = P_INPUT; end
                            else begin m_pos++; m_ph = P_SHOW; end
                        end
                    end
                    P_INPUT: begin
                        if (Btn == 0) begin
                            m_elapsed++;
                            if (m_elapsed == TO) begin m_ph = P_LOST; m_lto = 1; end
                        end else if (Btn == 4'(1 << m_seq[m_pos])) begin
                            m_press = 1; m_elapsed = 0;
                            if (m_pos < m_level - 1) m_pos++;
                            else begin
                                m_score = (m_score + m_level > 255) ? 255 : m_score + m_level;
                                if (m_level == ML) m_ph = P_WIN;
                                else begin m_level++; m_ph = P_GEN; end
                            end
                        end else begin
                            m_ph = P_LOST; m_lto = 0;
                        end
                    end
                    default: if (Start && ON) begin   // LOST, WIN
                        m_ph = P_INIT; m_level = 0; m_score = 0; m_lto = 0;
                    end
                endcase
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge Clk) begin
        logic [22:0] act, exp;
        act = {state_onehot, level, score, show_valid, show_color, press_ok, lost_timeout};
        exp = {8'(1 << m_ph), 2'(m_level), 8'(m_score), (m_ph == P_SHOW),
               (m_ph == P_SHOW) ? 2'(m_seq[m_pos]) : 2'd0, m_press, m_lto};
        chk("cycle_model", 32'(act), 32'(exp));
    end

    // Records the colour of each lit phase as it begins.
    int q_play[$];
    int prev[$];
    bit prev_sv = 0;
    always @(negedge Clk) begin
        if (show_valid && !prev_sv) q_play.push_back(int'(show_color));
        prev_sv = show_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_state(input logic [7:0] st, input int budget, input string name);
        int n = 0;
        while (state_onehot !== st && n < budget) begin
            @(negedge Clk);
            n++;
        end
        if (state_onehot !== st) begin
            checks++;
            failures++;
            $display("FAIL wait_%s actual=%0h expected=%0h", name, state_onehot, st);
        end
    endtask

    task automatic press(input logic [3:0] b);
        Btn = b;
        @(negedge Clk);
        Btn = 4'b0;
    endtask

    task automatic start_game();
        q_play.delete();
        prev.delete();
        Start = 1'b1;
        repeat (2) @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic replay(input int r);
        wait_state(8'h10, 200, "input");
        chk("play_len", q_play.size(), r);
        for (int i = 0; i < r - 1 && i < q_play.size() && i < prev.size(); i++)
            chk("play_prefix", q_play[i], prev[i]);
        prev = q_play;
        q_play.delete();
        foreach (prev[i]) begin
            press(4'(1 << prev[i]));
            chk("press_ok", press_ok, 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0, c1;
        int exp_score [3] = '{1, 3, 6};

        // Reset values
        repeat (3) @(negedge Clk);
        chk("rst_state", state_onehot, 8'h01);
        chk("rst_level", level, 0);
        chk("rst_score", score, 0);
        chk("rst_flags", {show_valid, show_color, press_ok, lost_timeout}, 0);
        Reset = 1'b0;
        ON = 1'b1;
        @(negedge Clk);
        chk("idle_initial", state_onehot, 8'h01);

        // First round timing: GEN 1 cycle, SHOW 4, GAP 2, then INPUT
        q_play.delete();
        prev.delete();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("gen_state", state_onehot, 8'h02);
        chk("gen_level", level, 1);
        n = 0;
        repeat (4) begin @(negedge Clk); if (show_valid) n++; end
        chk("show_len", n, 4);
        n = 0;
        repeat (2) begin @(negedge Clk); if (state_onehot == 8'h08) n++; end
        chk("gap_len", n, 2);
        @(negedge Clk);
        chk("input_state", state_onehot, 8'h10);
        chk("input_level", level, 1);
        chk("input_score", score, 0);

        // Full win
        for (int r = 1; r <= ML; r++) begin
            replay(r);
            chk("round_score", score, exp_score[r-1]);
        end
        chk("win_state", state_onehot, 8'h40);
        chk("win_level", level, 3);

        // Wrong colour on second press of round 2
        start_game();
        replay(1);
        wait_state(8'h10, 200, "input_r2");
        chk("r2_len", q_play.size(), 2);
        c0 = (q_play.size() > 0) ? q_play[0] : 0;
        c1 = (q_play.size() > 1) ? q_play[1] : 0;
        press(4'(1 << c0));
        press(4'(1 << ((c1 + 1) % 4)));
        chk("wrong_state", state_onehot, 8'h20);
        chk("wrong_lto", lost_timeout, 0);
        chk("wrong_score", score, 1);
        chk("wrong_level", level, 2);

        // Timeout after 20 idle cycles
        start_game();
        wait_state(8'h10, 200, "input_to");
        repeat (19) @(negedge Clk);
        chk("to_still_input", state_onehot, 8'h10);
        @(negedge Clk);
        chk("to_state", state_onehot, 8'h20);
        chk("to_lto", lost_timeout, 1);

        // Presses at the edge of the timeout window
        start_game();
        wait_state(8'h10, 200, "input_b1");
        c0 = (q_play.size() > 0) ? q_play[0] : 0;
        q_play.delete();
        repeat (19) @(negedge Clk);
        press(4'(1 << c0));
        chk("late_press_state", state_onehot, 8'h02);
        chk("late_press_ok", press_ok, 1);
        wait_state(8'h10, 200, "input_b2");
        chk("b2_prefix", (q_play.size() > 0) ? q_play[0] : -1, c0);
        c1 = (q_play.size() > 1) ? q_play[1] : 0;
        repeat (18) @(negedge Clk);
        press(4'(1 << c0));
        repeat (19) @(negedge Clk);
        chk("timer_restart", state_onehot, 8'h10);
        press(4'(1 << c1));
        chk("b2_state", state_onehot, 8'h02);
        chk("b2_score", score, 3);

        // Two buttons at once
        wait_state(8'h10, 200, "input_2b");
        press(4'b0011);
        chk("twobtn_state", state_onehot, 8'h20);
        chk("twobtn_lto", lost_timeout, 0);
        chk("twobtn_level", level, 3);
        chk("twobtn_score", score, 3);

        // Start in LOST -> INITIAL -> new game at level 1
        q_play.delete();
        Start = 1'b1;
        @(negedge Clk);
        chk("lost_to_init", state_onehot, 8'h01);
        chk("init_level", level, 0);
        @(negedge Clk);
        Start = 1'b0;
        chk("newgame_gen", state_onehot, 8'h02);
        chk("newgame_level", level, 1);
        chk("newgame_score", score, 0);

        // ON dropped during SHOW
        wait_state(8'h04, 20, "show");
        ON = 1'b0;
        @(negedge Clk);
        chk("off_state", state_onehot, 8'h80);
        chk("off_outputs", {show_valid, level, score}, 0);
        ON = 1'b1;
        start_game();

        // Asynchronous reset mid-GAP
        wait_state(8'h08, 40, "gap");
        #2 Reset = 1'b1;
        #1;
        chk("async_state", state_onehot, 8'h01);
        chk("async_outputs", {level, score, show_valid, show_color, press_ok, lost_timeout}, 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("after_reset_state", state_onehot, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
